jk_truth_sequencer: RTL
=======================

JK_TRUTH_SEQUENCER -- requirements
Module: jk_truth_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 27000000, meaning exCLK cycles per phase (valid range 1..2^27-1).
REQ-002 SHALL have port exCLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  level sampled each cycle; begins a test run.
REQ-005 SHALL have port Q  input  1  flip-flop true output under test.
REQ-006 SHALL have port Q1  input  1  flip-flop complement output under test.
REQ-007 SHALL have port J  output  1  J stimulus.
REQ-008 SHALL have port K  output  1  K stimulus.
REQ-009 SHALL have port SET  output  1  preset stimulus, active-low.
REQ-010 SHALL have port CLR  output  1  clear stimulus, active-low.
REQ-011 SHALL have port CP  output  1  generated flip-flop clock; the target samples on its falling edge.
REQ-012 SHALL have port BUSY  output  1  run in progress.
REQ-013 SHALL have port DONE  output  1  run finished; held until the next START.
REQ-014 SHALL have port PASS  output  1  qualified by DONE; 1 means all steps matched.
REQ-015 SHALL have port STEP  output  3  index of the current step.
REQ-016 SHALL have port ERR_STEP  output  3  index of the first failing step; qualified by DONE and PASS=0.

Function
REQ-017 SHALL run a fixed 8-step table (J,K,SET,CLR,expected Q, clocked?):
- step 0: 0,0,1,0 -> Q=0, async
- step 1: 0,0,0,1 -> Q=1, async
- step 2: 0,0,1,1 -> Q=1, clocked
- step 3: 0,1,1,1 -> Q=0, clocked
- step 4: 1,0,1,1 -> Q=1, clocked
- step 5: 1,1,1,1 -> Q=0, clocked
- step 6: 1,1,1,1 -> Q=1, clocked
- step 7: 0,0,1,1 -> Q=1, clocked
REQ-018 SHALL implement states IDLE, SETUP, CLK_HI, CLK_LO, CHECK and FIN.
REQ-019 SHALL go IDLE->SETUP with STEP=0 on a rising edge where START=1; in the same edge, BUSY=1, DONE=0 and PASS=0.
REQ-020 SHALL, in SETUP, drive that step's J/K/SET/CLR and hold for DIV cycles, then go to CLK_HI if clocked, otherwise to CHECK.
REQ-021 SHALL, in CLK_HI, hold CP=1 for DIV cycles, then go to CLK_LO; in CLK_LO, hold CP=0 for DIV cycles, then go to CHECK; CP=0 in all other states.
REQ-022 SHALL hold step stimulus unchanged from SETUP through CHECK of that step.
REQ-023 SHALL, in CHECK (1 cycle), pass the step iff Q equals the expected value and Q1 = ~Q.
REQ-024 SHALL, when the step passes and STEP<7, increment STEP and go to SETUP; when it passes and STEP=7, set PASS=1 and go to FIN.
REQ-025 SHALL, when the step fails, latch ERR_STEP=STEP, set PASS=0 and go to FIN (abort on first failure).
REQ-026 SHALL set DONE=1 and BUSY=0 in FIN, and restore idle stimulus (J=0, K=0, SET=1, CLR=1).
REQ-027 SHALL treat START=1 in FIN as IDLE does, clearing ERR_STEP to 0.
REQ-028 SHALL ignore START while BUSY=1.
REQ-029 SHALL total 20*DIV+8 cycles from the START edge to the FIN entry edge for a passing run.
REQ-030 SHALL use a 27-bit phase counter that reloads to 0 on every phase change and never wraps within a phase.

Reset
REQ-031 SHALL, on RST=1, immediately (without a clock edge) force state IDLE, J=0, K=0, SET=1, CLR=1, CP=0, BUSY=0, DONE=0, PASS=0, STEP=0, ERR_STEP=0 and counter=0.
REQ-032 SHALL apply REQ-031 when RST is asserted mid-run, including during CLK_HI: CP falls to 0 asynchronously, and no resume occurs after RST deasserts until a new START.

Structure
REQ-033 SHALL place the state enumeration, the 8-entry step-table constants and the counter width (27) in shared package jk_seq_pkg.
REQ-034 SHALL implement the phase counter as sub-module jk_phase_timer (inputs load and DIV, output expire).

Verification
REQ-035 SHALL verify: DIV=2 with an ideal 74LS112 model and one START pulse -> DONE=1, PASS=1 and STEP=7 exactly 48 cycles after the START edge.
REQ-036 SHALL verify: DIV=2 with the model's K input stuck at 0 -> DONE=1, PASS=0, ERR_STEP=3.
REQ-037 SHALL verify: DIV=2 with Q1 forced equal to Q -> fail at step 0, ERR_STEP=0, FIN reached after 3 cycles.
REQ-038 SHALL verify: RST pulsed during step 4 CLK_HI -> CP=0, BUSY=0, STEP=0 with no clock edge; then a new START gives a full pass.
REQ-039 SHALL verify: START held high throughout a run -> exactly one run while BUSY; in FIN it restarts on the next edge with DONE=0.
REQ-040 SHALL verify: DIV=1 -> passing run completes in 28 cycles, and each CP high pulse lasts exactly 1 cycle.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared state encoding, step table and widths for the JK flip-flop truth-table sequencer.
package jk_seq_pkg;

  localparam int unsigned CNT_W   = 27;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned N_STEPS = 8;
  localparam int unsigned STIM_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    CHECK  = 3'd4,
    FIN    = 3'd5
  } jk_state_e;

  typedef struct packed {
    logic j;
    logic k;
    logic set_n;
    logic clr_n;
    logic exp_q;
    logic clocked;
  } jk_step_t;

  // Columns: j, k, set_n, clr_n, exp_q, clocked
  localparam jk_step_t [0:N_STEPS-1] STEP_TABLE = '{
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}
  };

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  // {J, K, SET, CLR} with the flip-flop left free-running and untouched
  localparam logic [STIM_W-1:0] IDLE_STIM = 4'b0011;

  function automatic logic [STIM_W-1:0] stim_of(input jk_step_t s);
    return {s.j, s.k, s.set_n, s.clr_n};
  endfunction

endpackage

// File: rtl/jk_phase_timer.sv
// Phase counter: restarts from zero on load and flags the last cycle of a DIV-cycle phase.
module jk_phase_timer
  import jk_seq_pkg::*;
(
  input  logic             exCLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] DIV,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == DIV - CNT_W'(1));

  // Holding at the terminal count keeps the counter from wrapping inside a phase
  always_ff @(posedge exCLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jk_truth_sequencer.sv
// Walks a JK flip-flop through its truth table, clocking it on CP and checking Q/Q1 after each step.
module jk_truth_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned DIV = 27000000
) (
  input  logic              exCLK,
  input  logic              RST,
  input  logic              START,
  input  logic              Q,
  input  logic              Q1,
  output logic              J,
  output logic              K,
  output logic              SET,
  output logic              CLR,
  output logic              CP,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [STEP_W-1:0] STEP,
  output logic [STEP_W-1:0] ERR_STEP
);

  jk_state_e         state;
  logic              load;
  logic              expire;
  logic              cur_exp_q;
  logic              cur_clocked;
  logic              step_ok;
  logic [STIM_W-1:0] next_stim;

  assign cur_exp_q   = STEP_TABLE[STEP].exp_q;
  assign cur_clocked = STEP_TABLE[STEP].clocked;
  assign next_stim   = stim_of(STEP_TABLE[STEP + STEP_W'(1)]);
  assign step_ok     = (Q == cur_exp_q) && (Q1 != Q);

  // Timer only runs in the DIV-long phases; every phase change restarts it from zero
  assign load = !(state inside {SETUP, CLK_HI, CLK_LO}) || expire;

  jk_phase_timer u_timer (
    .exCLK  (exCLK),
    .RST    (RST),
    .load   (load),
    .DIV    (CNT_W'(DIV)),
    .expire (expire)
  );

  always_ff @(posedge exCLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      {J, K, SET, CLR} <= IDLE_STIM;
      CP               <= 1'b0;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      PASS             <= 1'b0;
      STEP             <= '0;
      ERR_STEP         <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            state            <= SETUP;
            {J, K, SET, CLR} <= stim_of(STEP_TABLE[0]);
            BUSY             <= 1'b1;
            DONE             <= 1'b0;
            PASS             <= 1'b0;
            STEP             <= '0;
            ERR_STEP         <= '0;
          end
        end
        SETUP: begin
          if (expire) begin
            state <= cur_clocked ? CLK_HI : CHECK;
            CP    <= cur_clocked;
          end
        end
        CLK_HI: begin
          if (expire) begin
            state <= CLK_LO;
            CP    <= 1'b0;
          end
        end
        CLK_LO: begin
          if (expire) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (step_ok && STEP != LAST_STEP) begin
            state            <= SETUP;
            STEP             <= STEP + STEP_W'(1);
            {J, K, SET, CLR} <= next_stim;
          end else begin
            // Last step passed or first failure: park the flip-flop and report
            state            <= FIN;
            {J, K, SET, CLR} <= IDLE_STIM;
            BUSY             <= 1'b0;
            DONE             <= 1'b1;
            PASS             <= step_ok;
            if (!step_ok) begin
              ERR_STEP <= STEP;
            end
          end
        end
        default: begin
          state            <= IDLE;
          {J, K, SET, CLR} <= IDLE_STIM;
          CP               <= 1'b0;
          BUSY             <= 1'b0;
        end
      endcase
    end
  end

endmodule
